// File: rtl/oflow_apb_master_if.sv
// oflow_apb_master_if: command/response channels and APB pins of the oflow APB initiator.
interface oflow_apb_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;
    logic [7:0]        err_count;
    logic              apb_psel;
    logic              apb_penable;
    logic              apb_pwrite;
    logic [ADDR_W-1:0] apb_addr;
    logic [DATA_W-1:0] apb_pwdata;
    logic              apb_pready;
    logic [DATA_W-1:0] apb_prdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, apb_pready, apb_prdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, err_count,
               apb_psel, apb_penable, apb_pwrite, apb_addr, apb_pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, apb_pready, apb_prdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, err_count,
               apb_psel, apb_penable, apb_pwrite, apb_addr, apb_pwdata
    );
endinterface

// File: rtl/oflow_apb_master.sv
// oflow_apb_master: single-outstanding APB initiator with valid/ready command and response
// channels, bounded pready wait and a saturating timeout counter.
module oflow_apb_master #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                clk,
    input logic                reset_N,
    oflow_apb_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic              ready_q;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        err_q, err_d;
    logic              write_q, write_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        write_d = write_q;
        error_d = error_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && ready_q) begin
                    write_d = bus.cmd_write;
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                // cnt_q holds the number of earlier low-pready ACCESS cycles
                if (bus.apb_pready) begin
                    rdata_d = write_q ? '0 : bus.apb_prdata;
                    error_d = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == LAST_WAIT) begin
                    rdata_d = '0;
                    error_d = 1'b1;
                    err_d   = (err_q == 8'hff) ? err_q : err_q + 8'd1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
        endcase
    end

    // cmd_ready is its own flop so it reads 0 during reset and rises on the first edge after
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= '0;
            write_q <= 1'b0;
            error_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            write_q <= write_d;
            error_q <= error_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.cmd_ready   = ready_q;
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_error   = error_q;
    assign bus.err_count   = err_q;
    assign bus.apb_psel    = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.apb_penable = (state_q == ACCESS);
    assign bus.apb_pwrite  = write_q;
    assign bus.apb_addr    = addr_q;
    assign bus.apb_pwdata  = wdata_q;
endmodule

// File: tb/tb_oflow_apb_master.sv
// tb_oflow_apb_master: randomized scoreboard bench with a behavioural APB slave and a
// transaction-level reference model of the initiator.
module tb_oflow_apb_master;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 16;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          error;
        logic [7:0]    errc;
        int            acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_N = 1'b0;

    oflow_apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    oflow_apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .reset_N(reset_N),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t          sb[$];
    exp_t          e;
    int            checks = 0;
    int            passes = 0;
    logic [DW-1:0] ref_mem[1024];
    logic [DW-1:0] smem[1024];
    int            ref_err = 0;
    int            cur_w = 0;
    logic          cur_write = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;
    int            rsp_mode = 0;
    int            stall = 0;
    int            sacc = 0;
    int            acc = 0;
    int            setup = 0;
    logic          exp_ready = 1'b0;
    logic          held = 1'b0;
    logic [DW-1:0] h_rdata;
    logic          h_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: a transfer with w wait states completes iff w < TO, else it times out.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int w);
        int n = 0;
        logic [DW-1:0] rd;
        @(negedge clk);
        while (bus.apb_psel && n < 300) begin
            @(negedge clk);
            n++;
        end
        cur_write = wr;
        cur_addr  = a;
        cur_wdata = d;
        cur_w     = w;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        while (!bus.cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            $display("FAIL cmd_accept_timeout: cmd_ready 0 expected 1");
            bus.cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (w < TO) begin
                rd = wr ? '0 : ref_mem[a];
                if (wr) ref_mem[a] = d;
                sb.push_back('{rd, 1'b0, 8'(ref_err), w + 1});
            end else begin
                if (ref_err < 255) ref_err++;
                sb.push_back('{'0, 1'b1, 8'(ref_err), TO});
            end
            #1 bus.cmd_valid = 1'b0;
        end
    endtask

    // APB slave: pready rises on ACCESS cycle number cur_w (0-based); noise outside ACCESS
    initial begin
        bus.apb_pready = 1'b0;
        bus.apb_prdata = '0;
        forever begin
            @(negedge clk);
            if (bus.apb_psel && bus.apb_penable) begin
                bus.apb_pready = (sacc == cur_w);
                bus.apb_prdata = bus.apb_pready ? smem[bus.apb_addr] : $urandom;
                if (bus.apb_pready && bus.apb_pwrite) smem[bus.apb_addr] = bus.apb_pwdata;
                sacc++;
            end else begin
                sacc = 0;
                bus.apb_pready = 1'($urandom_range(0, 1));
                bus.apb_prdata = $urandom;
            end
        end
    end

    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_mode == 0) bus.rsp_ready = 1'b1;
            else if (rsp_mode == 1) bus.rsp_ready = 1'($urandom_range(0, 1));
            else begin
                bus.rsp_ready = bus.rsp_valid && stall >= 5;
                stall = bus.rsp_valid ? stall + 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_N) begin
            acc = 0;
            setup = 0;
            exp_ready = 1'b0;
            held = 1'b0;
        end else begin
            if (exp_ready) begin
                chk("cmd_ready_after_rsp", 64'(bus.cmd_ready), 64'd1);
                exp_ready = 1'b0;
            end
            if (bus.apb_penable) chk("penable_without_psel", 64'(bus.apb_psel), 64'd1);
            if (bus.apb_psel) begin
                chk("paddr_stable", 64'(bus.apb_addr), 64'(cur_addr));
                chk("pwrite_stable", 64'(bus.apb_pwrite), 64'(cur_write));
                chk("pwdata_stable", 64'(bus.apb_pwdata), 64'(cur_wdata));
                if (bus.apb_penable) acc++;
                else setup++;
            end
            if (bus.rsp_valid) begin
                chk("cmd_ready_in_resp", 64'(bus.cmd_ready), 64'd0);
                if (held) begin
                    chk("rsp_rdata_hold", 64'(bus.rsp_rdata), 64'(h_rdata));
                    chk("rsp_error_hold", 64'(bus.rsp_error), 64'(h_err));
                end
                if (bus.rsp_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        $display("FAIL rsp_unexpected: response with empty scoreboard");
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                        chk("rsp_error", 64'(bus.rsp_error), 64'(e.error));
                        chk("err_count", 64'(bus.err_count), 64'(e.errc));
                        chk("access_cycles", 64'(acc), 64'(e.acc));
                        chk("setup_cycles", 64'(setup), 64'd1);
                    end
                    acc = 0;
                    setup = 0;
                    held = 1'b0;
                    exp_ready = 1'b1;
                end else begin
                    held = 1'b1;
                    h_rdata = bus.rsp_rdata;
                    h_err = bus.rsp_error;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        int w;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = '0;
            smem[i] = '0;
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        #12;
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_psel", 64'(bus.apb_psel), 64'd0);
        chk("rst_penable", 64'(bus.apb_penable), 64'd0);
        chk("rst_err_count", 64'(bus.err_count), 64'd0);
        chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("rst_rsp_error", 64'(bus.rsp_error), 64'd0);
        chk("rst_pwrite", 64'(bus.apb_pwrite), 64'd0);
        chk("rst_paddr", 64'(bus.apb_addr), 64'd0);
        chk("rst_pwdata", 64'(bus.apb_pwdata), 64'd0);
        @(negedge clk);
        reset_N = 1'b1;
        @(posedge clk);
        #1 chk("cmd_ready_after_reset", 64'(bus.cmd_ready), 64'd1);

        issue(1'b1, 10'h004, 32'h7, 0);
        issue(1'b0, 10'h004, $urandom, 3);
        issue(1'b0, 10'h008, $urandom, 100);
        issue(1'b0, 10'h004, $urandom, TO - 1);
        rsp_mode = 2;
        issue(1'b1, 10'h00c, $urandom, 0);
        issue(1'b0, 10'h00c, $urandom, 1);
        issue(1'b0, 10'h004, $urandom, 2);

        issue(1'b0, 10'h010, $urandom, 200);
        repeat (4) @(negedge clk);
        #2 reset_N = 1'b0;
        #1;
        chk("midrst_psel", 64'(bus.apb_psel), 64'd0);
        chk("midrst_penable", 64'(bus.apb_penable), 64'd0);
        chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("midrst_err_count", 64'(bus.err_count), 64'd0);
        sb.delete();
        ref_err = 0;
        rsp_mode = 0;
        repeat (2) @(negedge clk);
        reset_N = 1'b1;
        @(posedge clk);
        #1 chk("cmd_ready_after_midrst", 64'(bus.cmd_ready), 64'd1);
        issue(1'b1, 10'h014, 32'h55, 1);
        issue(1'b0, 10'h014, $urandom, 0);

        rsp_mode = 1;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            w = (r < 7) ? $urandom_range(0, 5) : (r == 7) ? TO - 1 : $urandom_range(TO - 2, 40);
            issue(1'($urandom_range(0, 1)), 10'($urandom_range(0, 7) * 4), $urandom, w);
        end

        rsp_mode = 0;
        for (int i = 0; i < 257; i++) issue(1'b0, 10'h020, $urandom, 255);

        n = 0;
        while ((sb.size() != 0 || bus.rsp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d responses outstanding expected 0", sb.size());
        end
        chk("err_count_saturated", 64'(bus.err_count), 64'd255);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/oflow_apb_master.md
Name: oflow_apb_master

Overview:
APB initiator that drives the oflow register file's APB slave port. A host-side controller or bench sequencer issues single read/write commands over a valid/ready interface. The block runs the APB SETUP/ACCESS phases, waits for pready with a bounded timeout, and returns read data plus an error flag over a valid/ready response interface. It sits between the configuration sequencer and the APB pins of oflow_top (apb_psel, apb_penable, apb_pwrite, apb_addr, apb_pwdata, apb_pready, apb_prdata). All logic runs on the same clock as the register file.

Parameters:
ADDR_W, 10, APB address width; must match REGISTER_ADD_LEN.
DATA_W, 32, APB data width; must match REGISTER_DATA_LEN.
TIMEOUT_CYCLES, 16, maximum ACCESS cycles with pready low before an error is reported; legal range 1..255.

Ports:
clk  in  1  single clock; drives the block and the APB bus.
reset_N  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high on a rising clk edge.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_W  register address.
cmd_wdata  in  DATA_W  write data; ignored for reads.
rsp_valid  out  1  response present.
rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
rsp_rdata  out  DATA_W  read data; 0 for writes and for timeouts.
rsp_error  out  1  1 = transaction timed out.
err_count  out  8  saturating count of timeouts since reset.
apb_psel  out  1  APB select.
apb_penable  out  1  APB enable.
apb_pwrite  out  1  APB direction.
apb_addr  out  ADDR_W  APB address.
apb_pwdata  out  DATA_W  APB write data.
apb_pready  in  1  APB slave ready.
apb_prdata  in  DATA_W  APB read data.

Behaviour:
- Reset (asynchronous, reset_N low):
  - State = IDLE.
  - All outputs 0, including apb_psel, apb_penable, rsp_valid and err_count.
  - Reset asserted mid-transaction drops apb_psel and apb_penable immediately. No response is generated for the aborted transaction.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1 only in this state; it is registered, not combinational from cmd_valid.
  - On handshake: latch cmd_write, cmd_addr and cmd_wdata into apb_pwrite, apb_addr and apb_pwdata; go to SETUP.
- SETUP (exactly 1 cycle):
  - apb_psel = 1, apb_penable = 0.
  - Clear the timeout counter; go to ACCESS.
- ACCESS:
  - apb_psel = 1, apb_penable = 1.
  - apb_addr, apb_pwrite and apb_pwdata stay stable for the whole transfer, from SETUP until return to IDLE.
  - apb_pready sampled high → completion:
    - rsp_rdata = apb_prdata for reads, 0 for writes; rsp_error = 0.
    - Go to RESP.
  - apb_pready low → increment the counter. If this is the TIMEOUT_CYCLES-th consecutive low cycle:
    - rsp_rdata = 0, rsp_error = 1; err_count += 1, saturating at 255.
    - Go to RESP.
  - pready high on the TIMEOUT_CYCLES-th ACCESS cycle is a normal completion, not an error.
- RESP:
  - apb_psel = 0, apb_penable = 0; rsp_valid = 1.
  - rsp_rdata and rsp_error held stable while rsp_valid = 1 and rsp_ready = 0.
  - On handshake: rsp_valid = 0; go to IDLE.
- Latency:
  - Accept at edge T → SETUP in cycle T+1, ACCESS from T+2.
  - Zero-wait pready at T+2 → rsp_valid high in T+3.
  - If rsp_ready is high in T+3, cmd_ready is high in T+4.
  - Minimum command-to-command spacing: 4 cycles.
- Only one transaction is outstanding at a time. cmd_ready stays low from SETUP through the RESP handshake.
- No APB protocol violations:
  - apb_penable never high without apb_psel.
  - apb_psel never deasserts in ACCESS before pready or timeout.
- apb_pready and apb_prdata are ignored outside ACCESS.

Test Plan:
- Write: cmd write addr=0x004, wdata=0x0000_0007, slave pready=1 immediately → psel high 2 cycles; penable high in the 2nd; pwrite=1, paddr=0x004, pwdata=7 stable; rsp_valid 1 cycle later with rsp_error=0, rsp_rdata=0.
- Read with 3 wait states: read addr=0x004; slave holds pready low 3 ACCESS cycles then returns prdata=0x0000_0007 → penable high 4 cycles; rsp_rdata=0x7, rsp_error=0.
- Timeout: TIMEOUT_CYCLES=16, pready held low → exactly 16 ACCESS cycles; psel drops; rsp_error=1, rsp_rdata=0, err_count=1. Repeat with pready high on the 16th cycle → rsp_error=0, err_count unchanged.
- Response backpressure: rsp_ready low for 5 cycles after completion → rsp_valid, rsp_rdata and rsp_error stable; cmd_ready stays 0; a new cmd_valid is not accepted until 1 cycle after the rsp handshake.
- Reset mid-ACCESS: assert reset_N low during wait states → psel, penable and rsp_valid go 0 without a clock edge. After release: cmd_ready=1 on the first edge, and a fresh write completes normally.
- err_count saturation: 256 forced timeouts → err_count holds at 255.
